// File: rtl/supersample_pkg.sv
`default_nettype none
// ============================================================================
// Module      : supersample_pkg
// Description : Shared widths, channel tags and block type for the chroma
//               supersampler.
// Revision    : 1.0 - initial release
// ============================================================================
package supersample_pkg;

    localparam int W   = 9;
    localparam int CH  = 3;
    localparam int CHW = $clog2(CH + 1);

    typedef enum logic [CHW-1:0] {
        CH_Y  = 0,
        CH_CB = 1,
        CH_CR = 2
    } ch_e;

    // [row][col] with row 0 at the top of the block
    typedef logic [7:0][7:0][W-1:0] blk_t;

endpackage
`default_nettype wire

// File: rtl/ss_quadrant.sv
`default_nettype none
// ============================================================================
// Module      : ss_quadrant
// Description : Combinational 2x chroma upsampler producing one 8x8 quadrant
//               (QR, QC) of the 16x16 MCU; averaging when SUPERSAMPLE_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_quadrant
    import supersample_pkg::*;
#(
    parameter int QR = 0,
    parameter int QC = 0
) (
    input  blk_t block_in,
    output blk_t quad_out
);

    localparam int c_SW = W + 2;

    // Each quadrant reads only part of the source block
    logic w_unused_in;
    assign w_unused_in = ^block_in;

    for (genvar r = 0; r < 8; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            localparam int c_Y = QR * 8 + r;
            localparam int c_X = QC * 8 + c;
            localparam int c_A = c_Y >> 1;
            localparam int c_B = c_X >> 1;
`ifdef SUPERSAMPLE_AVG_EN
            // Odd rows/cols blend with the next source sample; last one replicates
            localparam int c_A1 = ((c_Y % 2) == 1 && c_A < 7) ? c_A + 1 : c_A;
            localparam int c_B1 = ((c_X % 2) == 1 && c_B < 7) ? c_B + 1 : c_B;
            logic [c_SW-1:0] w_sum;
            assign w_sum = c_SW'(block_in[c_A][c_B])  + c_SW'(block_in[c_A1][c_B])
                         + c_SW'(block_in[c_A][c_B1]) + c_SW'(block_in[c_A1][c_B1])
                         + c_SW'(2);
            assign quad_out[r][c] = W'(w_sum >> 2);
`else
            assign quad_out[r][c] = block_in[c_A][c_B];
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/super_sample_top.sv
`default_nettype none
// ============================================================================
// Module      : super_sample_top
// Description : JPEG 4:2:0 -> 4:4:4 chroma supersampler, one block per cycle,
//               one register stage. SUPERSAMPLE_AVG_EN selects averaging.
// Revision    : 1.0 - initial release
// ============================================================================
module super_sample_top
    import supersample_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic [CHW-1:0] ch_in,
    input  blk_t           block_in,
    output blk_t           block_1_out,
    output blk_t           block_2_out,
    output blk_t           block_3_out,
    output blk_t           block_4_out,
    output logic [CHW-1:0] ch_out,
    output logic [3:0]     valid_out
);

    localparam logic [3:0] c_VALID_Y  = 4'b0001;
    localparam logic [3:0] c_VALID_CX = 4'b1111;

    blk_t           w_quad [4];
    blk_t           w_nxt  [4];
    logic           w_accept;
    logic           w_is_y;
    blk_t           r_blk  [4];
    logic [CHW-1:0] r_ch;
    logic [3:0]     r_valid;

    for (genvar q = 0; q < 4; q++) begin : g_quad
        ss_quadrant #(
            .QR (q >> 1),
            .QC (q & 1)
        ) u_quad (
            .block_in (block_in),
            .quad_out (w_quad[q])
        );
    end

    // Reserved tag 3 is dropped exactly like an idle cycle
    assign w_accept = valid_in && (ch_in <= CH_CR);
    assign w_is_y   = (ch_in == CH_Y);

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            w_nxt[q] = w_is_y ? '0 : w_quad[q];
        end
        if (w_is_y) begin
            w_nxt[0] = block_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < 4; q++) begin
                r_blk[q] <= '0;
            end
            r_ch    <= '0;
            r_valid <= '0;
        end else if (w_accept) begin
            for (int q = 0; q < 4; q++) begin
                r_blk[q] <= w_nxt[q];
            end
            r_ch    <= ch_in;
            r_valid <= w_is_y ? c_VALID_Y : c_VALID_CX;
        end else begin
            r_valid <= '0;
        end
    end

    assign block_1_out = r_blk[0];
    assign block_2_out = r_blk[1];
    assign block_3_out = r_blk[2];
    assign block_4_out = r_blk[3];
    assign ch_out      = r_ch;
    assign valid_out   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_super_sample_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_super_sample_top
// Description : Self-checking bench for super_sample_top against a reference
//               model of the 16x16 upsampled MCU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_super_sample_top;
    import supersample_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_in;
    logic [CHW-1:0] ch_in;
    blk_t           block_in;
    blk_t           block_1_out;
    blk_t           block_2_out;
    blk_t           block_3_out;
    blk_t           block_4_out;
    logic [CHW-1:0] ch_out;
    logic [3:0]     valid_out;

    int n_vec = 0;
    int n_err = 0;

    blk_t           m_blk [4];
    logic [CHW-1:0] m_ch;
    logic [3:0]     m_valid;

    always #5 clk = ~clk;

    super_sample_top dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ch_in       (ch_in),
        .block_in    (block_in),
        .block_1_out (block_1_out),
        .block_2_out (block_2_out),
        .block_3_out (block_3_out),
        .block_4_out (block_4_out),
        .ch_out      (ch_out),
        .valid_out   (valid_out)
    );

    // U[y][x] of the 16x16 upsampled plane
    function automatic logic [W-1:0] ref_u(input blk_t b, input int y, input int x);
`ifdef SUPERSAMPLE_AVG_EN
        int a, bb, a1, b1, s;
        a  = y / 2;
        bb = x / 2;
        a1 = (y % 2 == 1 && a < 7) ? a + 1 : a;
        b1 = (x % 2 == 1 && bb < 7) ? bb + 1 : bb;
        s  = int'(b[a][bb]) + int'(b[a1][bb]) + int'(b[a][b1]) + int'(b[a1][b1]);
        return W'((s + 2) / 4);
`else
        return b[y / 2][x / 2];
`endif
    endfunction

    function automatic blk_t ramp(input int x);
        blk_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j] = W'(x + 63 - 8 * i - j);
        return r;
    endfunction

    function automatic blk_t rand_blk();
        blk_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j] = W'($urandom);
        return r;
    endfunction

    task automatic model_clear();
        for (int q = 0; q < 4; q++) m_blk[q] = '0;
        m_ch    = '0;
        m_valid = '0;
    endtask

    task automatic step(input logic v, input logic [CHW-1:0] ch, input blk_t b);
        @(negedge clk);
        valid_in = v;
        ch_in    = ch;
        block_in = b;
        @(posedge clk);
        #1;
        if (!v || ch == 2'd3) begin
            m_valid = 4'b0000;
        end else if (ch == 2'd0) begin
            m_ch     = ch;
            m_valid  = 4'b0001;
            m_blk[0] = b;
            for (int q = 1; q < 4; q++) m_blk[q] = '0;
        end else begin
            m_ch    = ch;
            m_valid = 4'b1111;
            for (int q = 0; q < 4; q++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        m_blk[q][r][c] = ref_u(b, (q / 2) * 8 + r, (q % 2) * 8 + c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_in = 1'b0; ch_in = '0; block_in = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (valid_out !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", valid_out); end
        n_vec++; if (ch_out !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d expected 0", ch_out); end
        n_vec++; if (block_1_out !== '0 || block_2_out !== '0 || block_3_out !== '0 || block_4_out !== '0) begin
            n_err++; $display("FAIL reset_blocks: got b1=%h b4=%h expected all zero", block_1_out, block_4_out);
        end
    endtask

    task automatic test_y_block();
        step(1'b1, 2'd0, ramp(1));
        n_vec++; if (valid_out !== 4'b0001) begin n_err++; $display("FAIL y_valid: got %b expected 0001", valid_out); end
        n_vec++; if (ch_out !== 2'd0) begin n_err++; $display("FAIL y_ch: got %0d expected 0", ch_out); end
        n_vec++; if (block_1_out[0][0] !== 9'd64) begin n_err++; $display("FAIL y_b1_00: got %0d expected 64", block_1_out[0][0]); end
        n_vec++; if (block_1_out[7][7] !== 9'd1) begin n_err++; $display("FAIL y_b1_77: got %0d expected 1", block_1_out[7][7]); end
        n_vec++; if (block_2_out !== '0) begin n_err++; $display("FAIL y_b2_zero: got %h expected 0", block_2_out); end
        n_vec++; if (block_1_out !== m_blk[0]) begin n_err++; $display("FAIL y_b1: got %h expected %h", block_1_out, m_blk[0]); end
    endtask

    task automatic test_y_back_to_back();
        for (int x = 1; x <= 4; x++) begin
            step(1'b1, 2'd0, ramp(x));
            n_vec++; if (valid_out !== 4'b0001) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 0001", x, valid_out); end
            n_vec++; if (block_1_out[7][7] !== W'(x)) begin n_err++; $display("FAIL b2b_b1_77[%0d]: got %0d expected %0d", x, block_1_out[7][7], x); end
        end
    endtask

    task automatic test_chroma();
        step(1'b1, 2'd1, ramp(5));
        n_vec++; if (valid_out !== 4'b1111) begin n_err++; $display("FAIL cb_valid: got %b expected 1111", valid_out); end
        n_vec++; if (ch_out !== 2'd1) begin n_err++; $display("FAIL cb_ch: got %0d expected 1", ch_out); end
        n_vec++; if (block_1_out[0][0] !== 9'd68) begin n_err++; $display("FAIL cb_b1_00: got %0d expected 68", block_1_out[0][0]); end
        n_vec++; if (block_4_out[7][7] !== 9'd5) begin n_err++; $display("FAIL cb_b4_77: got %0d expected 5", block_4_out[7][7]); end
`ifdef SUPERSAMPLE_AVG_EN
        n_vec++; if (block_1_out[0][1] !== 9'd68) begin n_err++; $display("FAIL cb_avg_b1_01: got %0d expected 68", block_1_out[0][1]); end
        n_vec++; if (block_1_out[1][1] !== 9'd64) begin n_err++; $display("FAIL cb_avg_b1_11: got %0d expected 64", block_1_out[1][1]); end
`else
        n_vec++; if (block_1_out[1][1] !== 9'd68) begin n_err++; $display("FAIL cb_b1_11: got %0d expected 68", block_1_out[1][1]); end
        n_vec++; if (block_1_out[7][7] !== 9'd41) begin n_err++; $display("FAIL cb_b1_77: got %0d expected 41", block_1_out[7][7]); end
        n_vec++; if (block_2_out[0][0] !== 9'd64) begin n_err++; $display("FAIL cb_b2_00: got %0d expected 64", block_2_out[0][0]); end
        n_vec++; if (block_3_out[0][0] !== 9'd36) begin n_err++; $display("FAIL cb_b3_00: got %0d expected 36", block_3_out[0][0]); end
`endif
        n_vec++; if (block_1_out !== m_blk[0] || block_2_out !== m_blk[1] || block_3_out !== m_blk[2] || block_4_out !== m_blk[3]) begin
            n_err++; $display("FAIL cb_blocks: got b1=%h expected %h", block_1_out, m_blk[0]);
        end
    endtask

    task automatic test_cr_then_idle();
        step(1'b1, 2'd2, ramp(6));
        n_vec++; if (valid_out !== 4'b1111 || ch_out !== 2'd2) begin
            n_err++; $display("FAIL cr_tag: got valid=%b ch=%0d expected 1111/2", valid_out, ch_out);
        end
        step(1'b0, 2'd1, rand_blk());
        n_vec++; if (valid_out !== 4'b0000 || ch_out !== 2'd2) begin
            n_err++; $display("FAIL idle_tag: got valid=%b ch=%0d expected 0000/2", valid_out, ch_out);
        end
        n_vec++; if (block_1_out !== m_blk[0] || block_4_out !== m_blk[3]) begin
            n_err++; $display("FAIL idle_hold: got b1=%h expected %h", block_1_out, m_blk[0]);
        end
        step(1'b1, 2'd3, rand_blk());
        n_vec++; if (valid_out !== 4'b0000 || ch_out !== 2'd2 || block_2_out !== m_blk[1]) begin
            n_err++; $display("FAIL reserved_hold: got valid=%b ch=%0d b2=%h expected 0000/2/%h", valid_out, ch_out, block_2_out, m_blk[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            step(($urandom_range(0, 3) != 0), CHW'($urandom_range(0, 3)), rand_blk());
            n_vec++; if (valid_out !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, valid_out, m_valid); end
            n_vec++; if (ch_out !== m_ch) begin n_err++; $display("FAIL rnd_ch[%0d]: got %0d expected %0d", n, ch_out, m_ch); end
            n_vec++; if (block_1_out !== m_blk[0]) begin n_err++; $display("FAIL rnd_b1[%0d]: got %h expected %h", n, block_1_out, m_blk[0]); end
            n_vec++; if (block_2_out !== m_blk[1]) begin n_err++; $display("FAIL rnd_b2[%0d]: got %h expected %h", n, block_2_out, m_blk[1]); end
            n_vec++; if (block_3_out !== m_blk[2]) begin n_err++; $display("FAIL rnd_b3[%0d]: got %h expected %h", n, block_3_out, m_blk[2]); end
            n_vec++; if (block_4_out !== m_blk[3]) begin n_err++; $display("FAIL rnd_b4[%0d]: got %h expected %h", n, block_4_out, m_blk[3]); end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 2'd1, rand_blk());
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        n_vec++; if (valid_out !== 4'b0000 || ch_out !== 2'd0 || block_1_out !== '0 || block_4_out !== '0) begin
            n_err++; $display("FAIL midrst_clear: got valid=%b ch=%0d b1=%h expected all zero", valid_out, ch_out, block_1_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 2'd0, ramp(2));
        n_vec++; if (valid_out !== 4'b0001 || block_1_out[7][7] !== 9'd2) begin
            n_err++; $display("FAIL midrst_first: got valid=%b b1_77=%0d expected 0001/2", valid_out, block_1_out[7][7]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_y_block();
        test_y_back_to_back();
        test_chroma();
        test_cr_then_idle();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
